// File: rtl/led_pattern_gen.sv
// LED pattern engine: five selectable patterns paced by a step prescaler,
// mode advanced by a resynchronised push button.
module led_pattern_gen #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned STEP_DIV   = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                clk0,
  input  logic                rst,
  input  logic                btn,
  input  logic                freeze,
  output logic [NUM_LEDS-1:0] led,
  output logic [2:0]          mode,
  output logic                step_tick
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [NUM_LEDS-1:0] UNLIT    = {NUM_LEDS{ACTIVE_LOW}};

  typedef enum logic [2:0] {
    M_HEART  = 3'd0,
    M_BLINK  = 3'd1,
    M_CHASE  = 3'd2,
    M_BOUNCE = 3'd3,
    M_BINARY = 3'd4
  } mode_t;

  mode_t               state_q, state_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic                phase_q, phase_n;
  logic [POS_W-1:0]    pos_q, pos_n;
  logic                dir_q, dir_n;        // 0: moving up, 1: moving down
  logic [NUM_LEDS-1:0] bcnt_q, bcnt_n;
  logic [NUM_LEDS-1:0] led_q, led_n;
  logic                tick_q, tick_n;
  logic                s1_q, s2_q, s3_q;
  logic                press_c;
  logic                step_c;

  // Logical lit pattern for a given pattern state (bit i = LED i lit).
  function automatic logic [NUM_LEDS-1:0] pattern(input mode_t m, input logic ph,
                                                  input logic [POS_W-1:0] p,
                                                  input logic [NUM_LEDS-1:0] b);
    logic [NUM_LEDS-1:0] l;
    l = NUM_LEDS'(1);
    case (m)
      M_HEART:           l = ph ? '1 : NUM_LEDS'(1);
      M_BLINK:           l = ph ? '0 : '1;
      M_CHASE, M_BOUNCE: l = NUM_LEDS'(1) << p;
      M_BINARY:          l = b;
      default:           l = NUM_LEDS'(1);
    endcase
    return l;
  endfunction

  assign press_c = s2_q & ~s3_q;
  assign step_c  = (cnt_q == CNT_LAST) & ~freeze;

  // Next-state: invalid mode recovery, then press, then prescaler/step.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    phase_n = phase_q;
    pos_n   = pos_q;
    dir_n   = dir_q;
    bcnt_n  = bcnt_q;
    tick_n  = 1'b0;

    if (state_q > M_BINARY || press_c) begin
      if (state_q >= M_BINARY) begin
        state_n = M_HEART;
      end else begin
        state_n = mode_t'(state_q + 3'd1);
      end
      cnt_n   = '0;
      phase_n = 1'b0;
      pos_n   = '0;
      dir_n   = 1'b0;
      bcnt_n  = '0;
    end else if (!freeze) begin
      cnt_n = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      if (step_c) begin
        tick_n = 1'b1;
        case (state_q)
          M_HEART, M_BLINK: phase_n = ~phase_q;
          M_CHASE:          pos_n = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
          M_BOUNCE: begin
            // Reverse at either end; a single LED never moves.
            if (!dir_q) begin
              if (pos_q == POS_LAST) begin
                dir_n = 1'b1;
                pos_n = (POS_LAST == '0) ? pos_q : pos_q - POS_W'(1);
              end else begin
                pos_n = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_n = 1'b0;
                pos_n = (POS_LAST == '0) ? pos_q : pos_q + POS_W'(1);
              end else begin
                pos_n = pos_q - POS_W'(1);
              end
            end
          end
          M_BINARY:         bcnt_n = bcnt_q + NUM_LEDS'(1);
          default:          ;
        endcase
      end
    end

    led_n = pattern(state_n, phase_n, pos_n, bcnt_n) ^ UNLIT;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      state_q <= M_HEART;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      bcnt_q  <= '0;
      led_q   <= UNLIT;
      tick_q  <= 1'b0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      phase_q <= phase_n;
      pos_q   <= pos_n;
      dir_q   <= dir_n;
      bcnt_q  <= bcnt_n;
      led_q   <= led_n;
      tick_q  <= tick_n;
      s1_q    <= btn;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  assign led       = led_q;
  assign mode      = state_q;
  assign step_tick = tick_q;

endmodule
